// File: rtl/store_pkg.sv
// Shared definitions for the store narrowing path: size encodings, lane record
// and the big-endian byte-lane mapping function.
package store_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } st_size_e;

   typedef struct packed {
      logic [31:0] wdata;
      logic [3:0]  be;
   } lane_t;

   // Big-endian lanes: be[3] covers bits 31:24, i.e. byte offset 0.
   function automatic lane_t lane_map(input st_size_e sz, input logic [1:0] a, input logic [31:0] d);
      lane_t l;
      l.wdata = 32'h0000_0000;
      l.be    = 4'b0000;
      case (sz)
         SZ_BYTE: begin
            l.wdata = {4{d[7:0]}};
            l.be    = 4'b1000 >> a;
         end
         SZ_HALF: begin
            l.wdata = {2{d[15:0]}};
            l.be    = a[1] ? 4'b0011 : 4'b1100;
         end
         SZ_WORD: begin
            l.wdata = d;
            l.be    = 4'b1111;
         end
         default: begin
            l.wdata = 32'h0000_0000;
            l.be    = 4'b0000;
         end
      endcase
      return l;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; head entry is presented combinationally
// from registered storage, so it stays stable until popped.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 68
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         din_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok_s, pop_ok_s;

   assign full_o    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == CW'(0));
   assign push_ok_s = push_i && !full_o;
   assign pop_ok_s  = pop_i && !empty_o;
   assign dout_o    = mem_q[rd_ptr_q];
   assign count_o   = count_q;

   always_comb begin
      count_d = count_q;
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok_s) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
      end
   end

   // Storage needs no reset: pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push_ok_s) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/store_data_narrower.sv
// Narrows register store data onto big-endian byte lanes and posts it through a
// DEPTH-entry write queue. Define STORE_MISALIGN_TRAP_EN to reject misaligned stores.
module store_data_narrower
   import store_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      st_valid,
   output logic                      st_ready,
   input  logic [ADDR_W-1:0]         st_addr,
   input  logic [31:0]               st_data,
   input  logic [1:0]                st_size,
   output logic                      mem_valid,
   input  logic                      mem_ready,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [31:0]               mem_wdata,
   output logic [3:0]                mem_be,
   output logic                      st_err,
   output logic [$clog2(DEPTH):0]    pending
);

   localparam int EW = ADDR_W + 36;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      lane_t             lane;
   } entry_t;

   st_size_e size_s;
   logic [1:0] lane_a_s;
   logic       reject_s, hs_s, push_s, full_s, empty_s, err_q;
   entry_t     entry_s, head_s;
   logic [EW-1:0] head_bits_s;

   assign size_s = st_size_e'(st_size);

   always_comb begin
      lane_a_s = st_addr[1:0];
`ifdef STORE_MISALIGN_TRAP_EN
      reject_s = (size_s == SZ_RSVD) ||
                 ((size_s == SZ_HALF) && st_addr[0]) ||
                 ((size_s == SZ_WORD) && (st_addr[1:0] != 2'b00));
`else
      reject_s = (size_s == SZ_RSVD);
      // Misaligned stores are silently aligned down rather than trapped.
      case (size_s)
         SZ_HALF: lane_a_s = {st_addr[1], 1'b0};
         SZ_WORD: lane_a_s = 2'b00;
         default: lane_a_s = st_addr[1:0];
      endcase
`endif
      entry_s.addr = {st_addr[ADDR_W-1:2], 2'b00};
      entry_s.lane = lane_map(size_s, lane_a_s, st_data);
   end

   assign st_ready = rst_n && !full_s;
   assign hs_s     = st_valid && st_ready;
   assign push_s   = hs_s && !reject_s;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_s),
      .din_i   (entry_s),
      .pop_i   (mem_valid && mem_ready),
      .dout_o  (head_bits_s),
      .full_o  (full_s),
      .empty_o (empty_s),
      .count_o (pending)
   );

   assign head_s    = entry_t'(head_bits_s);
   assign mem_valid = !empty_s;
   assign mem_addr  = head_s.addr;
   assign mem_wdata = head_s.lane.wdata;
   assign mem_be    = head_s.lane.be;
   assign st_err    = err_q;

   always_ff @(posedge clk) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= hs_s && reject_s;
   end

endmodule
